// File: rtl/eth_pkg.sv
// eth_pkg -- shared Ethernet framing definitions.
//   Header length and byte offsets of the 14-byte Ethernet II header, the
//   framer state encoding, and a helper that packs header fields into
//   on-wire byte order (byte n at bits [8n+:8]). Used by the TX header
//   inserter and by the RX EtherType filter.
package eth_pkg;

  localparam int HDR_LEN  = 14;
  localparam int HDR_BITS = HDR_LEN * 8;

  // Byte offsets inside the header.
  localparam int DEST_OFF = 0;
  localparam int SRC_OFF  = 6;
  localparam int TYPE_OFF = 12;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HEADER  = 2'd1,
    ST_PAYLOAD = 2'd2,
    ST_FLUSH   = 2'd3
  } eth_state_e;

  // MACs go out most-significant byte first; EtherType is big-endian.
  function automatic logic [HDR_BITS-1:0] eth_build_hdr(
    input logic [47:0] dest_mac,
    input logic [47:0] src_mac,
    input logic [15:0] eth_type
  );
    logic [HDR_BITS-1:0] h;
    h = '0;
    for (int i = 0; i < 6; i++) begin
      h[(DEST_OFF + i) * 8 +: 8] = dest_mac[47 - 8 * i -: 8];
      h[(SRC_OFF + i) * 8 +: 8]  = src_mac[47 - 8 * i -: 8];
    end
    h[TYPE_OFF * 8 +: 8]       = eth_type[15:8];
    h[(TYPE_OFF + 1) * 8 +: 8] = eth_type[7:0];
    return h;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// axis_out_reg -- single AXI-stream output register slice.
//   Holds one beat. A new beat may be loaded whenever the slot is free
//   (empty, or the held beat is being taken this cycle). While the
//   downstream stalls, the held beat stays unchanged.
// Ports:
//   clk, rst        clock, synchronous active-high reset (clears all outputs)
//   in_valid/data/keep/last/user   beat to load (only honoured when slot_free)
//   slot_free       register can accept a beat this cycle
//   m_axis_*        registered AXI-stream master
module axis_out_reg #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [KEEP_WIDTH-1:0] in_keep,
  input  logic                  in_last,
  input  logic [USER_WIDTH-1:0] in_user,
  output logic                  slot_free,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser
);

  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
  logic                  tlast_q, tlast_d;
  logic [USER_WIDTH-1:0] tuser_q, tuser_d;

  assign slot_free = !tvalid_q || m_axis_tready;

  always_comb begin
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    if (slot_free) begin
      tvalid_d = in_valid;
      if (in_valid) begin
        tdata_d = in_data;
        tkeep_d = in_keep;
        tlast_d = in_last;
        tuser_d = in_user;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
    end else begin
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
    end
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tuser  = tuser_q;

endmodule

// File: rtl/eth_hdr_insert.sv
// eth_hdr_insert -- prepends a 14-byte Ethernet header to AXI-stream frames.
//   A header (dest MAC, src MAC, EtherType) is accepted in IDLE, then the
//   payload stream is shifted up by 14 bytes behind it. The top 14 bytes of
//   every input beat are carried into the next output beat; if the final
//   input beat does not fit, one extra FLUSH beat drains the carry.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   s_hdr_valid/ready           header handshake
//   s_hdr_dest_mac/src_mac/type header fields
//   s_axis_*                    payload input stream (tkeep contiguous from bit 0)
//   m_axis_*                    framed output stream (one register stage)
//   frame_count                 number of output frames completed (wraps)
module eth_hdr_insert import eth_pkg::*; #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_hdr_valid,
  output logic                  s_hdr_ready,
  input  logic [47:0]           s_hdr_dest_mac,
  input  logic [47:0]           s_hdr_src_mac,
  input  logic [15:0]           s_hdr_type,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  output logic [31:0]           frame_count
);

  // Byte counts up to KEEP_WIDTH + HDR_LEN must be representable.
  localparam int CNT_W = $clog2(KEEP_WIDTH + HDR_LEN + 1);
  // Largest number of input bytes on a last beat that still fits, with the
  // 14 shifted-in bytes, in a single output beat.
  localparam logic [CNT_W-1:0] FIT_MAX = CNT_W'(KEEP_WIDTH - HDR_LEN);
  localparam logic [CNT_W-1:0] HDR_CNT = CNT_W'(HDR_LEN);

  function automatic logic [CNT_W-1:0] keep_count(input logic [KEEP_WIDTH-1:0] k);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      c = c + {{(CNT_W-1){1'b0}}, k[i]};
    end
    return c;
  endfunction

  function automatic logic [KEEP_WIDTH-1:0] keep_mask(input logic [CNT_W-1:0] n);
    logic [KEEP_WIDTH-1:0] m;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      m[i] = (CNT_W'(i) < n);
    end
    return m;
  endfunction

  eth_state_e            state_q, state_d;
  logic [HDR_BITS-1:0]   hdr_q, hdr_d;
  logic [HDR_BITS-1:0]   carry_q, carry_d;
  logic [USER_WIDTH-1:0] carry_user_q, carry_user_d;
  logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
  logic [31:0]           frame_count_q, frame_count_d;

  logic                  slot_free;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic                  out_last;
  logic [USER_WIDTH-1:0] out_user;
  logic [HDR_BITS-1:0]   prefix;
  logic [CNT_W-1:0]      in_cnt;

  // Handshakes are forced low while reset is held so nothing is taken
  // during the reset cycle.
  assign s_hdr_ready   = !rst && (state_q == ST_IDLE);
  assign s_axis_tready = !rst && slot_free &&
                         ((state_q == ST_HEADER) || (state_q == ST_PAYLOAD));
  assign frame_count   = frame_count_q;

  // HEADER and PAYLOAD differ only in what fills the low 14 bytes.
  assign prefix = (state_q == ST_HEADER) ? hdr_q : carry_q;
  assign in_cnt = keep_count(s_axis_tkeep);

  always_comb begin
    state_d      = state_q;
    hdr_d        = hdr_q;
    carry_d      = carry_q;
    carry_user_d = carry_user_q;
    flush_cnt_d  = flush_cnt_q;
    out_valid    = 1'b0;
    out_data     = '0;
    out_keep     = '0;
    out_last     = 1'b0;
    out_user     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (s_hdr_valid && s_hdr_ready) begin
          hdr_d   = eth_build_hdr(s_hdr_dest_mac, s_hdr_src_mac, s_hdr_type);
          state_d = ST_HEADER;
        end
      end

      ST_HEADER, ST_PAYLOAD: begin
        if (s_axis_tvalid && s_axis_tready) begin
          out_valid    = 1'b1;
          out_data     = {s_axis_tdata[DATA_WIDTH-HDR_BITS-1:0], prefix};
          out_user     = s_axis_tuser;
          carry_d      = s_axis_tdata[DATA_WIDTH-1 -: HDR_BITS];
          carry_user_d = s_axis_tuser;
          if (s_axis_tlast) begin
            if (in_cnt <= FIT_MAX) begin
              out_keep = keep_mask(in_cnt + HDR_CNT);
              out_last = 1'b1;
              state_d  = ST_IDLE;
            end else begin
              out_keep    = '1;
              flush_cnt_d = in_cnt - FIT_MAX;
              state_d     = ST_FLUSH;
            end
          end else begin
            out_keep = '1;
            state_d  = ST_PAYLOAD;
          end
        end
      end

      ST_FLUSH: begin
        if (slot_free) begin
          out_valid = 1'b1;
          out_data  = {{(DATA_WIDTH-HDR_BITS){1'b0}}, carry_q};
          out_keep  = keep_mask(flush_cnt_q);
          out_last  = 1'b1;
          out_user  = carry_user_q;
          state_d   = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_count_d = frame_count_q;
    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      frame_count_d = frame_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hdr_q         <= '0;
      carry_q       <= '0;
      carry_user_q  <= '0;
      flush_cnt_q   <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      hdr_q         <= hdr_d;
      carry_q       <= carry_d;
      carry_user_q  <= carry_user_d;
      flush_cnt_q   <= flush_cnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  axis_out_reg #(
    .DATA_WIDTH (DATA_WIDTH),
    .KEEP_WIDTH (KEEP_WIDTH),
    .USER_WIDTH (USER_WIDTH)
  ) u_out_reg (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (out_valid),
    .in_data       (out_data),
    .in_keep       (out_keep),
    .in_last       (out_last),
    .in_user       (out_user),
    .slot_free     (slot_free),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser)
  );

endmodule

// File: tb/tb_eth_hdr_insert.sv
// Directed bench for eth_hdr_insert at DATA_WIDTH=128 (16 bytes per beat).
module tb_eth_hdr_insert;

  localparam int DW = 128;
  localparam int KW = 16;
  localparam int UW = 1;

  logic          clk;
  logic          rst;
  logic          s_hdr_valid;
  logic          s_hdr_ready;
  logic [47:0]   s_hdr_dest_mac;
  logic [47:0]   s_hdr_src_mac;
  logic [15:0]   s_hdr_type;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tlast;
  logic [UW-1:0] s_axis_tuser;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          m_axis_tlast;
  logic [UW-1:0] m_axis_tuser;
  logic [31:0]   frame_count;

  eth_hdr_insert #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .USER_WIDTH(UW)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_hdr_valid    (s_hdr_valid),
    .s_hdr_ready    (s_hdr_ready),
    .s_hdr_dest_mac (s_hdr_dest_mac),
    .s_hdr_src_mac  (s_hdr_src_mac),
    .s_hdr_type     (s_hdr_type),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tuser   (s_axis_tuser),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tuser   (m_axis_tuser),
    .frame_count    (frame_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
    logic [UW-1:0] u;
  } beat_t;

  beat_t beats[$];
  int    tests_run    = 0;
  int    tests_failed = 0;
  int    stall_err    = 0;
  int    stall_seen   = 0;
  logic  prev_stall   = 1'b0;
  beat_t prev_beat;

  // Expected header beats (bytes 0..13 header, 14..15 first payload bytes).
  localparam logic [DW-1:0] EXP_T1   = 128'hBBAA0008_01000000_0002FFFF_FFFFFFFF;
  localparam logic [DW-1:0] EXP_32A  = 128'h01000008_01000000_0002FFFF_FFFFFFFF;
  localparam logic [DW-1:0] EXP_32B  = 128'h11100F0E_0D0C0B0A_09080706_05040302;
  localparam logic [DW-1:0] EXP_32C  = 128'h00001F1E_1D1C1B1A_19181716_15141312;
  localparam logic [DW-1:0] EXP_F2   = 128'h0201DD86_0F0E0D0C_0B0A6655_44332211;
  localparam logic [DW-1:0] PAY_32_0 = 128'h0F0E0D0C_0B0A0908_07060504_03020100;
  localparam logic [DW-1:0] PAY_32_1 = 128'h1F1E1D1C_1B1A1918_17161514_13121110;

  // Record every transferred output beat; also verify the beat is held
  // unchanged across any stall.
  always @(negedge clk) begin
    beat_t cur;
    cur.d = m_axis_tdata;
    cur.k = m_axis_tkeep;
    cur.l = m_axis_tlast;
    cur.u = m_axis_tuser;
    if (prev_stall && !rst) begin
      if (!(m_axis_tvalid === 1'b1 && cur === prev_beat)) stall_err++;
    end
    if (!rst && m_axis_tvalid && m_axis_tready) beats.push_back(cur);
    prev_stall = !rst && m_axis_tvalid && !m_axis_tready;
    if (prev_stall) stall_seen++;
    prev_beat = cur;
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    tests_run++;
    tests_failed++;
    $error("FAIL %s: timeout waiting for handshake", tag);
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [DW-1:0] d,
                          input logic [KW-1:0] k, input logic l, input logic [UW-1:0] u);
    beat_t b;
    if (idx < beats.size()) b = beats[idx];
    else b = 'x;
    chk({tag, "_data"}, b.d, d);
    chk({tag, "_keep"}, {112'd0, b.k}, {112'd0, k});
    chk({tag, "_last"}, {127'd0, b.l}, {127'd0, l});
    chk({tag, "_user"}, {127'd0, b.u}, {127'd0, u});
  endtask

  task automatic send_hdr(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t);
    int n;
    s_hdr_dest_mac = d;
    s_hdr_src_mac  = s;
    s_hdr_type     = t;
    s_hdr_valid    = 1'b1;
    #1;
    n = 0;
    while (!s_hdr_ready && n < 200) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 200) timeout("send_hdr");
    @(posedge clk); #1;
    s_hdr_valid = 1'b0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input logic l, input logic [UW-1:0] u);
    int n;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    #1;
    n = 0;
    while (!s_axis_tready && n < 200) begin
      @(posedge clk); #2; n++;
    end
    if (n >= 200) timeout("send_beat");
    @(posedge clk); #1;
    if (l) s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_frames(input logic [31:0] target);
    int n;
    n = 0;
    while (frame_count !== target && n < 100) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic std_hdr();
    send_hdr(48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0800);
  endtask

  initial begin
    logic [3:0] pat;
    int tl_cnt;
    pat = 4'b1001;
    rst = 1'b1;
    s_hdr_valid = 1'b0;
    s_hdr_dest_mac = '0;
    s_hdr_src_mac = '0;
    s_hdr_type = '0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = '0;
    m_axis_tready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_hdr_ready", s_hdr_ready, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_frame_count", frame_count, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #2;
    chk("idle_hdr_ready", s_hdr_ready, 1);
    chk("idle_s_tready", s_axis_tready, 0);

    // Two-byte payload fits in a single output beat
    beats.delete();
    std_hdr();
    send_beat(128'hBBAA, 16'h0003, 1'b1, 1'b1);
    chk("t1_latency_valid", m_axis_tvalid, 1);
    wait_frames(32'd1);
    chk("t1_frame_count", frame_count, 1);
    chk("t1_nbeats", beats.size(), 1);
    chk_beat("t1_b0", 0, EXP_T1, 16'hFFFF, 1'b1, 1'b1);

    // Three-byte payload spills one byte into a flush beat
    beats.delete();
    std_hdr();
    send_beat(128'hCCBBAA, 16'h0007, 1'b1, 1'b1);
    wait_frames(32'd2);
    chk("t2_frame_count", frame_count, 2);
    chk("t2_nbeats", beats.size(), 2);
    chk_beat("t2_b0", 0, EXP_T1, 16'hFFFF, 1'b0, 1'b1);
    chk_beat("t2_b1", 1, 128'hCC, 16'h0001, 1'b1, 1'b1);

    // 32-byte payload with output backpressure 1,0,0,1
    beats.delete();
    std_hdr();
    fork
      begin
        send_beat(PAY_32_0, 16'hFFFF, 1'b0, 1'b0);
        send_beat(PAY_32_1, 16'hFFFF, 1'b1, 1'b1);
      end
      begin
        for (int c = 0; c < 24; c++) begin
          m_axis_tready = pat[c % 4];
          @(posedge clk); #1;
        end
        m_axis_tready = 1'b1;
      end
    join
    wait_frames(32'd3);
    chk("t3_frame_count", frame_count, 3);
    chk("t3_nbeats", beats.size(), 3);
    chk_beat("t3_b0", 0, EXP_32A, 16'hFFFF, 1'b0, 1'b0);
    chk_beat("t3_b1", 1, EXP_32B, 16'hFFFF, 1'b0, 1'b1);
    chk_beat("t3_b2", 2, EXP_32C, 16'h3FFF, 1'b1, 1'b1);
    chk("t3_stall_seen", stall_seen > 0, 1);
    chk("t3_stall_stable", stall_err, 0);

    // Payload presented before its header must stall
    beats.delete();
    s_axis_tdata  = 128'hBBAA;
    s_axis_tkeep  = 16'h0003;
    s_axis_tlast  = 1'b1;
    s_axis_tuser  = 1'b1;
    s_axis_tvalid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("t4_early_tready", s_axis_tready, 0);
      @(posedge clk); #1;
    end
    std_hdr();
    send_beat(128'hBBAA, 16'h0003, 1'b1, 1'b1);
    wait_frames(32'd4);
    chk("t4_frame_count", frame_count, 4);
    chk("t4_nbeats", beats.size(), 1);
    chk_beat("t4_b0", 0, EXP_T1, 16'hFFFF, 1'b1, 1'b1);

    // Second header offered while the first frame is in flight
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t5_count_cleared", frame_count, 0);
    beats.delete();
    std_hdr();
    fork
      begin
        send_beat(PAY_32_0, 16'hFFFF, 1'b0, 1'b0);
        send_beat(PAY_32_1, 16'hFFFF, 1'b1, 1'b1);
      end
      begin
        int n;
        s_hdr_dest_mac = 48'h1122_3344_5566;
        s_hdr_src_mac  = 48'h0A0B_0C0D_0E0F;
        s_hdr_type     = 16'h86DD;
        s_hdr_valid    = 1'b1;
        #1;
        n = 0;
        while (!s_hdr_ready && n < 200) begin
          @(posedge clk); #2; n++;
        end
        if (n >= 200) timeout("t5_hdr2");
        chk("t5_hdr2_blocked", n > 0, 1);
        chk("t5_hdr2_after_tlast", {m_axis_tvalid, m_axis_tlast}, 2'b11);
        @(posedge clk); #1;
        s_hdr_valid = 1'b0;
      end
    join
    send_beat(128'h0201, 16'h0003, 1'b1, 1'b0);
    wait_frames(32'd2);
    chk("t5_frame_count", frame_count, 2);
    chk("t5_nbeats", beats.size(), 4);
    chk_beat("t5_b0", 0, EXP_32A, 16'hFFFF, 1'b0, 1'b0);
    chk_beat("t5_b2", 2, EXP_32C, 16'h3FFF, 1'b1, 1'b1);
    chk_beat("t5_b3", 3, EXP_F2, 16'hFFFF, 1'b1, 1'b0);

    // Reset in the middle of a four-beat payload
    beats.delete();
    std_hdr();
    send_beat(PAY_32_0, 16'hFFFF, 1'b0, 1'b0);
    send_beat(PAY_32_1, 16'hFFFF, 1'b0, 1'b1);
    rst = 1'b1;
    s_axis_tvalid = 1'b0;
    #1;
    chk("t6_rst_hdr_ready", s_hdr_ready, 0);
    chk("t6_rst_s_tready", s_axis_tready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t6_m_tvalid", m_axis_tvalid, 0);
    chk("t6_m_tlast", m_axis_tlast, 0);
    chk("t6_frame_count", frame_count, 0);
    tl_cnt = 0;
    foreach (beats[i]) if (beats[i].l) tl_cnt++;
    chk("t6_no_partial_tlast", tl_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("t6_still_idle", m_axis_tvalid, 0);
    beats.delete();
    std_hdr();
    send_beat(128'hBBAA, 16'h0003, 1'b1, 1'b1);
    wait_frames(32'd1);
    chk("t6_after_frame_count", frame_count, 1);
    chk("t6_after_nbeats", beats.size(), 1);
    chk_beat("t6_after_b0", 0, EXP_T1, 16'hFFFF, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
